serv_rf_dbg_arbiter: RTL and testbench

SERV_RF_DBG_ARBITER -- requirements
Module: serv_rf_dbg_arbiter

---
 rtl/serv_rf_dbg_arbiter.sv | 160 ++++++++++++++++
 tb/tb_serv_rf_dbg_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_rf_dbg_arbiter.sv
// Shares the SERV register-file RAM between the CPU and a debug register port.
// The CPU always wins; debug words are split into width-bit beats that are issued only in CPU-idle cycles.
module serv_rf_dbg_arbiter #(
  parameter int width     = 8,
  parameter int rf_count  = 16,
  parameter int csr_count = 8,
  localparam int beats    = 32 / width,
  localparam int aw       = $clog2((rf_count + csr_count) * beats)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_cpu_waddr,
  input  logic [width-1:0] i_cpu_wdata,
  input  logic             i_cpu_wen,
  input  logic [aw-1:0]    i_cpu_raddr,
  input  logic             i_cpu_ren,
  output logic [width-1:0] o_cpu_rdata,
  input  logic             i_halted,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [5:0]       i_dbg_reg,
  input  logic [31:0]      i_dbg_wdat,
  output logic [31:0]      o_dbg_rdat,
  output logic             o_dbg_ack,
  output logic             o_dbg_err,
  output logic             o_dbg_busy,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

  localparam int unsigned NREG = rf_count + csr_count;
  localparam int BW = $clog2(beats + 1);

  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

  state_t          state_q;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   cap_q;
  logic            pend_q;
  logic [5:0]      reg_q;
  logic [31:0]     wdat_q;
  logic [31:0]     rbuf_q;
  logic [31:0]     rbuf_d;
  logic [31:0]     rdat_q;
  logic            ack_q;
  logic            err_q;
  logic            busy_q;

  logic            cpu_act;
  logic            dbg_wen;
  logic            dbg_ren;
  logic            capture;
  logic            rd_last;
  logic [aw-1:0]   dbg_addr;
  logic [width-1:0] dbg_slice;

  always_comb begin
    cpu_act   = i_cpu_ren | i_cpu_wen;
    dbg_addr  = aw'(32'(reg_q) * 32'(beats) + 32'(beat_q));
    dbg_slice = width'(wdat_q >> (32'(beat_q) * 32'(width)));
    // Debug enables are gated by reset so an abandoned transfer never touches the RAM.
    dbg_wen   = !i_rst && (state_q == WR) && !cpu_act;
    dbg_ren   = !i_rst && (state_q == RD) && !cpu_act && (beat_q < BW'(beats));
    capture   = (state_q == RD) && pend_q;
    rd_last   = capture && (cap_q == BW'(beats - 1));
    rbuf_d    = rbuf_q;
    if (capture)
      rbuf_d[32'(cap_q) * 32'(width) +: width] = i_rdata;

    o_wen   = i_cpu_wen | dbg_wen;
    o_waddr = dbg_wen ? dbg_addr  : i_cpu_waddr;
    o_wdata = dbg_wen ? dbg_slice : i_cpu_wdata;
    o_ren   = i_cpu_ren | dbg_ren;
    o_raddr = dbg_ren ? dbg_addr  : i_cpu_raddr;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      reg_q   <= '0;
      wdat_q  <= '0;
      rbuf_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      pend_q <= dbg_ren;
      case (state_q)
        IDLE: begin
          if (i_dbg_req && i_halted) begin
            beat_q <= '0;
            cap_q  <= '0;
            reg_q  <= i_dbg_reg;
            wdat_q <= i_dbg_wdat;
            busy_q <= 1'b1;
            if (32'(i_dbg_reg) >= NREG) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdat_q  <= '0;
            end else if (i_dbg_reg == '0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              err_q   <= 1'b0;
              if (!i_dbg_we)
                rdat_q <= '0;
            end else begin
              state_q <= i_dbg_we ? WR : RD;
              err_q   <= 1'b0;
            end
          end
        end
        WR: begin
          if (dbg_wen) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == BW'(beats - 1)) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        RD: begin
          if (dbg_ren)
            beat_q <= beat_q + 1'b1;
          rbuf_q <= rbuf_d;
          if (capture)
            cap_q <= cap_q + 1'b1;
          // The visible read word only changes once the whole word has been gathered.
          if (rd_last) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            rdat_q  <= rbuf_d;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cpu_rdata = i_rdata;
  assign o_dbg_rdat  = rdat_q;
  assign o_dbg_ack   = ack_q;
  assign o_dbg_err   = err_q;
  assign o_dbg_busy  = busy_q;

endmodule

// File: tb/tb_serv_rf_dbg_arbiter.sv
// Bench for serv_rf_dbg_arbiter (width=8): directed vector table, corner sequences, then random
// debug traffic against a word-level register model with CPU read interference.
module tb_serv_rf_dbg_arbiter;
  localparam int W     = 8;
  localparam int BEATS = 4;
  localparam int NREG  = 24;
  localparam int AW    = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpu_waddr = '0;
  logic [W-1:0]  cpu_wdata = '0;
  logic          cpu_wen = 1'b0;
  logic [AW-1:0] cpu_raddr = '0;
  logic          cpu_ren = 1'b0;
  logic [W-1:0]  cpu_rdata;
  logic          halted = 1'b0;
  logic          dbg_req = 1'b0;
  logic          dbg_we = 1'b0;
  logic [5:0]    dbg_reg = '0;
  logic [31:0]   dbg_wdat = '0;
  logic [31:0]   dbg_rdat;
  logic          dbg_ack, dbg_err, dbg_busy;
  logic [AW-1:0] waddr, raddr;
  logic [W-1:0]  wdata;
  logic          wen, ren;
  logic [W-1:0]  rdata_q = '0;
  logic [W-1:0]  mem [128] = '{default: 8'h00};

  int n_chk = 0;
  int n_fail = 0;

  serv_rf_dbg_arbiter #(.width(8), .rf_count(16), .csr_count(8)) dut (
    .clk(clk), .i_rst(rst),
    .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata), .i_cpu_wen(cpu_wen),
    .i_cpu_raddr(cpu_raddr), .i_cpu_ren(cpu_ren), .o_cpu_rdata(cpu_rdata),
    .i_halted(halted), .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_reg(dbg_reg),
    .i_dbg_wdat(dbg_wdat), .o_dbg_rdat(dbg_rdat), .o_dbg_ack(dbg_ack),
    .o_dbg_err(dbg_err), .o_dbg_busy(dbg_busy),
    .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen),
    .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata_q)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle read latency
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata_q <= mem[raddr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Word-level reference model
  logic [31:0] mregs [NREG];
  logic [31:0] mlast;

  task automatic model_apply(input bit we, input int unsigned r, input logic [31:0] wd);
    if (r >= NREG) mlast = '0;
    else if (we) begin
      if (r != 0) mregs[r] = wd;
    end else mlast = (r == 0) ? 32'h0 : mregs[r];
  endtask

  function automatic int exp_lat(input bit we, input int unsigned r, input logic [31:0] mask);
    int idle = 0;
    if (r >= NREG || r == 0) return 1;
    for (int k = 1; k < 200; k++) begin
      if (k > 32 || !mask[k-1]) idle++;
      if (idle == BEATS) return we ? k + 1 : k + 2;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One debug transaction; mask bit k-1 drives i_cpu_ren in the k-th cycle after accept.
  task automatic do_txn(input bit we, input int unsigned r, input logic [31:0] wd,
                        input logic [31:0] mask, input bit drop,
                        output int lat, output logic [31:0] rdat, output logic err);
    logic [AW-1:0] wa[$];
    logic [W-1:0]  wv[$];
    logic [AW-1:0] ra[$];
    bit valid;
    valid = (r < NREG) && (r != 0);
    tick();
    dbg_req = 1'b1; halted = 1'b1; dbg_we = we; dbg_reg = 6'(r); dbg_wdat = wd;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
    lat = -1; rdat = '0; err = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (drop && k == 2) begin dbg_req = 1'b0; halted = 1'b0; end
      cpu_ren = (k <= 32) ? mask[k-1] : 1'b0;
      cpu_raddr = AW'($urandom);
      #3;
      if (cpu_ren) chk("cpu_raddr_pass", 32'(raddr), 32'(cpu_raddr));
      chk("cpu_rdata_pass", 32'(cpu_rdata), 32'(rdata_q));
      if (wen && !cpu_wen) begin wa.push_back(waddr); wv.push_back(wdata); end
      if (ren && !cpu_ren) ra.push_back(raddr);
      if (dbg_ack) begin
        lat = k; rdat = dbg_rdat; err = dbg_err;
        chk("busy_in_ack", 32'(dbg_busy), 32'd1);
        break;
      end
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: got no ack in 80 cycles, required ack");
    end
    tick();
    dbg_req = 1'b0; halted = 1'b1; cpu_ren = 1'b0;
    #3;
    chk("busy_after_ack", 32'(dbg_busy), 32'd0);
    chk("ack_one_cycle", 32'(dbg_ack), 32'd0);
    chk("dbg_wen_count", 32'(wa.size()), (we && valid) ? 32'(BEATS) : 32'd0);
    chk("dbg_ren_count", 32'(ra.size()), (!we && valid) ? 32'(BEATS) : 32'd0);
    foreach (wa[b]) begin
      chk("wr_addr", 32'(wa[b]), 32'(r * BEATS + b));
      chk("wr_data", 32'(wv[b]), (wd >> (8 * b)) & 32'hFF);
    end
    foreach (ra[b]) chk("rd_addr", 32'(ra[b]), 32'(r * BEATS + b));
  endtask

  typedef struct {
    bit          we;
    int unsigned r;
    logic [31:0] wdat;
    logic [31:0] mask;
    int          lat;
    bit          err;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int lat;
    logic [31:0] rdat;
    logic err;
    bit we, drop;
    int unsigned r;
    logic [31:0] wd, mask;

    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    mlast = '0;

    vecs[0]  = '{1'b1, 5,  32'hDEADBEEF, 32'h0, 5,  1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 5,  32'h0,        32'h0, 6,  1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5,  32'h0,        32'h6, 8,  1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 0,  32'h12345678, 32'h0, 1,  1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 24, 32'h12345678, 32'h0, 1,  1'b1, 32'h00000000};
    vecs[5]  = '{1'b0, 0,  32'h0,        32'h0, 1,  1'b0, 32'h00000000};
    vecs[6]  = '{1'b1, 23, 32'hA5A55A5A, 32'h0, 5,  1'b0, 32'h00000000};
    vecs[7]  = '{1'b0, 23, 32'h0,        32'h0, 6,  1'b0, 32'hA5A55A5A};
    vecs[8]  = '{1'b0, 63, 32'h0,        32'h0, 1,  1'b1, 32'h00000000};
    vecs[9]  = '{1'b1, 1,  32'h00000001, 32'h1, 6,  1'b0, 32'h00000000};
    vecs[10] = '{1'b0, 1,  32'h0,        32'hF, 10, 1'b0, 32'h00000001};

    rst = 1'b1;
    tick();
    tick();
    #3;
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_err", 32'(dbg_err), 32'd0);
    chk("rst_busy", 32'(dbg_busy), 32'd0);
    chk("rst_rdat", dbg_rdat, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].we, vecs[i].r, vecs[i].wdat, vecs[i].mask, 1'b0, lat, rdat, err);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_rdat", i), rdat, vecs[i].rdat);
      model_apply(vecs[i].we, vecs[i].r, vecs[i].wdat);
    end

    // Not halted: request must wait; accepted in the cycle halted rises
    tick();
    dbg_req = 1'b1; halted = 1'b0; dbg_we = 1'b0; dbg_reg = 6'd5;
    for (int j = 0; j < 3; j++) begin
      tick();
      #3;
      chk("unhalted_busy", 32'(dbg_busy), 32'd0);
      chk("unhalted_ack", 32'(dbg_ack), 32'd0);
    end
    do_txn(1'b0, 5, 32'h0, 32'h0, 1'b0, lat, rdat, err);
    chk("halt_rise_lat", 32'(lat), 32'd6);
    chk("halt_rise_rdat", rdat, 32'hDEADBEEF);
    model_apply(1'b0, 5, 32'h0);

    // Reset after three beats of a write to reg 7
    tick();
    dbg_req = 1'b1; halted = 1'b1; dbg_we = 1'b1; dbg_reg = 6'd7; dbg_wdat = 32'h11223344;
    for (int k = 1; k <= 3; k++) begin
      tick();
      dbg_req = 1'b0;
      #3;
      chk("pre_rst_wen", 32'(wen), 32'd1);
    end
    tick();
    rst = 1'b1; cpu_ren = 1'b1; cpu_raddr = 7'h55;
    #3;
    chk("rst_cycle_wen", 32'(wen), 32'd0);
    chk("rst_cpu_ren_pass", 32'(ren), 32'd1);
    chk("rst_cpu_raddr_pass", 32'(raddr), 32'h55);
    tick();
    rst = 1'b0; cpu_ren = 1'b0;
    for (int j = 0; j < 6; j++) begin
      #3;
      chk("post_rst_wen", 32'(wen), 32'd0);
      chk("post_rst_ack", 32'(dbg_ack), 32'd0);
      chk("post_rst_busy", 32'(dbg_busy), 32'd0);
      tick();
    end
    chk("post_rst_rdat", dbg_rdat, 32'd0);
    mregs[7] = 32'h00223344;
    mlast = '0;
    do_txn(1'b0, 7, 32'h0, 32'h0, 1'b0, lat, rdat, err);
    chk("partial_write_read", rdat, 32'h00223344);
    model_apply(1'b0, 7, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      r    = ($urandom_range(0, 9) == 0) ? $urandom_range(24, 63) : $urandom_range(0, 23);
      wd   = $urandom;
      mask = $urandom & $urandom;
      drop = ($urandom_range(0, 3) == 0);
      do_txn(we, r, wd, mask, drop, lat, rdat, err);
      model_apply(we, r, wd);
      chk("rand_lat", 32'(lat), 32'(exp_lat(we, r, mask)));
      chk("rand_err", 32'(err), (r >= NREG) ? 32'd1 : 32'd0);
      chk("rand_rdat", rdat, mlast);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
